wait_state_controller: RTL and testbench

Parametrised wait-state and READY generator for the KFPCJr chipset, successor to the fixed three-source ready logic. Supports CHANNELS device channels, each with a programmable wait-state count and an asynchronous device-ready input, plus a bus timeout. Sits between the bus arbiter (command strobes) and the CPU RDY pin. All timing is qualified by the CPU clock-enable strobes.

---
 rtl/wait_state_controller.sv | 197 +++++++++++++++++++
 tb/tb_wait_state_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_controller.sv
// Wait-state and READY generator: per-channel programmable wait counts,
// synchronised device-ready inputs and a bus timeout, paced by CPU clock ticks.
module wait_state_controller #(
    parameter int CHANNELS         = 4,
    parameter int WAIT_WIDTH       = 4,
    parameter int IO_DEFAULT_WAIT  = 1,
    parameter int MEM_DEFAULT_WAIT = 0,
    parameter int INTA_WAIT        = 1,
    parameter int TIMEOUT          = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cpu_clock_posedge,
    input  logic                           cpu_clock_negedge,
    input  logic                           ALE,
    input  logic                           IO_OR_M,
    input  logic                           RD_N,
    input  logic                           WR_N,
    input  logic                           INTA_N,
    input  logic                           HLDA,
    input  logic [CHANNELS-1:0]            channel_select,
    input  logic [CHANNELS*WAIT_WIDTH-1:0] channel_wait,
    input  logic [CHANNELS-1:0]            channel_ready,
    input  logic                           timeout_clear,
    output logic                           RDY,
    output logic                           busy,
    output logic                           timeout_pulse,
    output logic                           timeout_status
);

    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WAIT_WIDTH-1:0] IO_W   = WAIT_WIDTH'(IO_DEFAULT_WAIT);
    localparam logic [WAIT_WIDTH-1:0] MEM_W  = WAIT_WIDTH'(MEM_DEFAULT_WAIT);
    localparam logic [WAIT_WIDTH-1:0] INTA_W = WAIT_WIDTH'(INTA_WAIT);
    localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, COUNT, EXT_WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [CHANNELS-1:0]   ready_meta_q, ready_meta_d;
    logic [CHANNELS-1:0]   ready_sync_q, ready_sync_d;
    logic                  is_io_q, is_io_d;
    logic                  hit_q, hit_d;
    logic [CHAN_W-1:0]     chan_q, chan_d;
    logic [WAIT_WIDTH-1:0] count_q, count_d;
    logic [7:0]            timer_q, timer_d;
    logic                  rdy_q, rdy_d;
    logic                  pulse_q, pulse_d;
    logic                  status_q, status_d;

    logic [WAIT_WIDTH-1:0] chan_wait;
    logic [WAIT_WIDTH-1:0] wait_count;
    logic                  chan_ready;
    logic                  ready_src;
    logic                  cmd;

    // Address phase: the lowest-numbered asserted select wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        ready_meta_d = channel_ready;
        ready_sync_d = ready_meta_q;
        is_io_d      = is_io_q;
        hit_d        = hit_q;
        chan_d       = chan_q;
        if (ALE) begin
            is_io_d = IO_OR_M;
            hit_d   = |channel_select;
            chan_d  = '0;
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (channel_select[i]) chan_d = CHAN_W'(i);
            end
        end
    end

    always_comb begin
        chan_wait  = '0;
        chan_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_q == CHAN_W'(i)) begin
                chan_wait  = channel_wait[i*WAIT_WIDTH +: WAIT_WIDTH];
                chan_ready = ready_sync_q[i];
            end
        end
        if (!INTA_N)      wait_count = INTA_W;
        else if (hit_q)   wait_count = chan_wait;
        else if (is_io_q) wait_count = IO_W;
        else              wait_count = MEM_W;
        ready_src = hit_q ? chan_ready : 1'b1;
        cmd       = ~RD_N | ~WR_N | ~INTA_N;
    end

    always_comb begin
        state_d  = state_q;
        rdy_d    = rdy_q;
        count_d  = count_q;
        timer_d  = timer_q;
        pulse_d  = 1'b0;
        status_d = timeout_clear ? 1'b0 : status_q;

        if (HLDA) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
            count_d = '0;
            timer_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_clock_negedge && cmd) begin
                        if (wait_count != '0) begin
                            state_d = COUNT;
                            rdy_d   = 1'b0;
                            count_d = wait_count;
                        end else if (ready_src) begin
                            state_d = DONE;
                        end else begin
                            state_d = EXT_WAIT;
                            rdy_d   = 1'b0;
                            timer_d = '0;
                        end
                    end
                end
                COUNT: begin
                    if (!cmd) begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                        count_d = '0;
                        timer_d = '0;
                    end else if (cpu_clock_posedge) begin
                        count_d = count_q - 1'b1;
                        if (count_q == WAIT_WIDTH'(1)) begin
                            state_d = EXT_WAIT;
                            timer_d = '0;
                        end
                    end
                end
                EXT_WAIT: begin
                    // A ready device always beats a timeout landing on the same tick.
                    if (!cmd) begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                        count_d = '0;
                        timer_d = '0;
                    end else if (cpu_clock_negedge && ready_src) begin
                        state_d = DONE;
                        rdy_d   = 1'b1;
                    end else if (cpu_clock_negedge && timer_q == TIMEOUT_CNT) begin
                        state_d  = DONE;
                        rdy_d    = 1'b1;
                        pulse_d  = 1'b1;
                        status_d = 1'b1;
                    end else if (cpu_clock_posedge && timer_q != TIMEOUT_CNT) begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                DONE: begin
                    if (!cmd) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_meta_q <= '1;
            ready_sync_q <= '1;
            is_io_q      <= 1'b0;
            hit_q        <= 1'b0;
            chan_q       <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            rdy_q        <= 1'b1;
            pulse_q      <= 1'b0;
            status_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q      <= state_d;
            ready_meta_q <= ready_meta_d;
            ready_sync_q <= ready_sync_d;
            is_io_q      <= is_io_d;
            hit_q        <= hit_d;
            chan_q       <= chan_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            rdy_q        <= rdy_d;
            pulse_q      <= pulse_d;
            status_q     <= status_d;
        end
    end

    assign RDY            = rdy_q;
    assign busy           = (state_q == COUNT) || (state_q == EXT_WAIT);
    assign timeout_pulse  = pulse_q;
    assign timeout_status = status_q;

endmodule

// File: tb/tb_wait_state_controller.sv
// Directed bench: each bus cycle pushes its expected RDY-low time and timeout
// behaviour to a scoreboard, then the measured cycle is popped and compared.
module tb_wait_state_controller;

    localparam int CH = 4;
    localparam int WW = 4;

    localparam int EV_NONE  = 0;
    localparam int EV_ABORT = 1;
    localparam int EV_HLDA  = 2;
    localparam int EV_READY = 3;
    localparam int EV_RESET = 4;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_INTA = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             cpu_clock_posedge, cpu_clock_negedge;
    logic             ALE, IO_OR_M, RD_N, WR_N, INTA_N, HLDA;
    logic [CH-1:0]    channel_select;
    logic [CH*WW-1:0] channel_wait;
    logic [CH-1:0]    channel_ready;
    logic             timeout_clear;
    logic             RDY, busy, timeout_pulse, timeout_status;

    wait_state_controller #(
        .CHANNELS(CH), .WAIT_WIDTH(WW), .IO_DEFAULT_WAIT(1), .MEM_DEFAULT_WAIT(0),
        .INTA_WAIT(1), .TIMEOUT(255)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
        .ALE(ALE), .IO_OR_M(IO_OR_M), .RD_N(RD_N), .WR_N(WR_N), .INTA_N(INTA_N),
        .HLDA(HLDA), .channel_select(channel_select), .channel_wait(channel_wait),
        .channel_ready(channel_ready), .timeout_clear(timeout_clear),
        .RDY(RDY), .busy(busy), .timeout_pulse(timeout_pulse), .timeout_status(timeout_status)
    );

    always #5 clock = ~clock;

    typedef struct {
        int low;
        int pulses;
        int released;
        int busy_seen;
        int busy_rel;
        int rdy_rel;
        int status_rel;
    } res_t;

    res_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   phase  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One system clock; a CPU clock is four system clocks, rising tick on
    // phase 0 and falling tick on phase 2.
    task automatic step();
        @(negedge clock);
        phase = (phase + 1) % 4;
        cpu_clock_posedge = (phase == 0);
        cpu_clock_negedge = (phase == 2);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_cycle(input logic io, input logic [CH-1:0] sel, input int kind,
                             input int ev, input int ev_at, input int max_steps,
                             output res_t got);
        bit seen;
        got = '{default: 0};
        seen = 0;
        while (phase != 3) step();
        step();
        ALE = 1'b1; IO_OR_M = io; channel_select = sel;
        step();
        ALE = 1'b0; channel_select = '0;
        RD_N = (kind != K_RD); WR_N = (kind != K_WR); INTA_N = (kind != K_INTA);
        for (int j = 1; j <= max_steps; j++) begin
            step();
            if (RDY === 1'b0) begin
                got.low++;
                seen = 1;
            end
            if (busy === 1'b1) got.busy_seen = 1;
            if (timeout_pulse === 1'b1) got.pulses++;
            if (seen && RDY === 1'b1) begin
                got.released = 1; got.rdy_rel = RDY; got.busy_rel = busy;
                got.status_rel = timeout_status;
                break;
            end
            if (j == ev_at) begin
                if (ev == EV_ABORT) begin
                    RD_N = 1'b1; WR_N = 1'b1; INTA_N = 1'b1;
                end else if (ev == EV_HLDA) begin
                    HLDA = 1'b1;
                end else if (ev == EV_READY) begin
                    channel_ready = '1;
                end else if (ev == EV_RESET) begin
                    reset = 1'b1;
                    #1;
                    got.released = 1; got.rdy_rel = RDY; got.busy_rel = busy;
                    got.status_rel = timeout_status;
                    break;
                end
            end
        end
        RD_N = 1'b1; WR_N = 1'b1; INTA_N = 1'b1; timeout_clear = 1'b0;
        step();
        reset = 1'b0; HLDA = 1'b0;
        steps(2);
    endtask

    task automatic run(input string tag, input logic io, input logic [CH-1:0] sel,
                       input int kind, input int ev, input int ev_at, input int max_steps,
                       input int exp_low, input int exp_pulses, input int exp_status);
        res_t e, got;
        e = '{default: 0};
        e.low = exp_low; e.pulses = exp_pulses; e.released = (exp_low > 0);
        e.busy_seen = (exp_low > 0); e.busy_rel = 0; e.rdy_rel = 1; e.status_rel = exp_status;
        sb_q.push_back(e);
        bus_cycle(io, sel, kind, ev, ev_at, max_steps, got);
        e = sb_q.pop_front();
        check({tag, ":low"}, got.low, e.low);
        check({tag, ":released"}, got.released, e.released);
        check({tag, ":pulses"}, got.pulses, e.pulses);
        check({tag, ":busy_seen"}, got.busy_seen, e.busy_seen);
        if (got.released != 0) begin
            check({tag, ":rdy_rel"}, got.rdy_rel, e.rdy_rel);
            check({tag, ":busy_rel"}, got.busy_rel, e.busy_rel);
            check({tag, ":status_rel"}, got.status_rel, e.status_rel);
        end
        check({tag, ":end_rdy"}, int'(RDY), 1);
        check({tag, ":end_busy"}, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu_clock_posedge = 1'b0; cpu_clock_negedge = 1'b0;
        ALE = 1'b0; IO_OR_M = 1'b0; RD_N = 1'b1; WR_N = 1'b1; INTA_N = 1'b1; HLDA = 1'b0;
        channel_select = '0;
        channel_wait   = {4'd15, 4'd3, 4'd0, 4'd0};
        channel_ready  = '1;
        timeout_clear  = 1'b0;
        steps(3);
        check("reset:rdy", int'(RDY), 1);
        check("reset:busy", int'(busy), 0);
        check("reset:pulse", int'(timeout_pulse), 0);
        check("reset:status", int'(timeout_status), 0);
        reset = 1'b0;
        steps(2);

        // Wait states times four system clocks per CPU clock.
        run("mem_nosel",   1'b0, 4'b0000, K_RD,   EV_NONE, 0, 16,  0,  0, 0);
        run("io_nosel",    1'b1, 4'b0000, K_RD,   EV_NONE, 0, 40,  4,  0, 0);
        run("inta_prio",   1'b0, 4'b0100, K_INTA, EV_NONE, 0, 40,  4,  0, 0);
        run("io_ch2",      1'b1, 4'b0100, K_RD,   EV_NONE, 0, 60,  12, 0, 0);
        run("lowest_sel",  1'b1, 4'b1100, K_WR,   EV_NONE, 0, 60,  12, 0, 0);
        run("ch3_w15",     1'b0, 4'b1000, K_RD,   EV_NONE, 0, 100, 60, 0, 0);
        run("ch1_rdy_hi",  1'b0, 4'b0010, K_RD,   EV_NONE, 0, 16,  0,  0, 0);

        // Rise set before posedge P(j+1) is usable at P(j+3); release on next phase-2 edge.
        channel_ready = 4'b1101; steps(3);
        run("ch1_sync_a",  1'b0, 4'b0010, K_RD,   EV_READY, 39, 100, 40, 0, 0);
        channel_ready = 4'b1101; steps(3);
        run("ch1_sync_b",  1'b0, 4'b0010, K_RD,   EV_READY, 40, 100, 44, 0, 0);

        channel_ready = 4'b1110; steps(3);
        run("timeout_a",   1'b0, 4'b0001, K_RD,   EV_NONE, 0, 1100, 1020, 1, 1);
        check("status_sticky", int'(timeout_status), 1);
        timeout_clear = 1'b1; step(); timeout_clear = 1'b0; step();
        check("status_cleared", int'(timeout_status), 0);

        channel_ready = '1;
        channel_wait  = {4'd5, 4'd3, 4'd0, 4'd0};
        steps(3);
        run("abort_w5",    1'b0, 4'b1000, K_RD,   EV_ABORT, 10, 100, 9, 0, 0);
        check("abort:status", int'(timeout_status), 0);

        channel_ready = 4'b1110; steps(3);
        run("hlda_ext",    1'b0, 4'b0001, K_RD,   EV_HLDA, 20, 100, 19, 0, 0);

        timeout_clear = 1'b1;
        run("timeout_setwins", 1'b0, 4'b0001, K_RD, EV_NONE, 0, 1100, 1020, 1, 1);
        check("setwins:status", int'(timeout_status), 1);

        channel_ready = '1; steps(3);
        run("reset_count", 1'b0, 4'b1000, K_RD,   EV_RESET, 10, 100, 9, 0, 0);
        check("reset_mid:status", int'(timeout_status), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
